data_mem: RTL and testbench
===========================

# data_mem

Parametrised byte-addressed, big-endian data memory for the core's load/store stage; successor to the fixed-size store-only RAM. Adds configurable depth, a request/response handshake with registered read data, sign/zero-extended byte/half/word loads, range checking, and a sequential post-reset clear. It sits between the execute stage's memory-op decode and write-back.

## Interface
- ADDR_W, 12: byte-address width actually decoded; depth = 2^ADDR_W bytes, organised as 2^(ADDR_W-2) 32-bit words; legal range 4..20.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = skip the clear and go straight to ready.
- CLK  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  access size: SIZE_B, SIZE_H, SIZE_W; the fourth code is reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  qualified by rsp_valid; access rejected.
- busy  out  1  high while the clear sequence runs.

## Operation
- FSM states: INIT (clearing), READY. Leave reset in INIT if CLEAR_ON_RESET=1, else READY.
- INIT: writes zero to word index init_idx each cycle, from 0 to 2^(ADDR_W-2)-1, then enters READY. busy=1 and req_ready=0 throughout. Requests are ignored, not queued.
- READY: req_ready=1 and busy=0. A request is accepted when req_valid && req_ready. At most one is accepted per cycle.
- Fault conditions:
  - req_addr[31:ADDR_W] nonzero (out of range).
  - req_size is the reserved code.
  - Misalignment (see Configuration).
- A faulting request writes nothing. It returns rsp_fault=1 and rsp_rdata=0.
- Store: big-endian byte placement. Byte lands at addr. Half: [15:8] at addr, [7:0] at addr+1. Word: [31:24] at addr through [7:0] at addr+3. Untouched bytes keep their value. Implement with per-lane byte enables on the word array.
- Load: select the byte, half or word from the addressed word (big-endian lanes), then extend per req_unsigned. A word ignores req_unsigned.
- Stores produce an acknowledge response: rsp_valid=1, rsp_rdata=0, rsp_fault=0.
- There is no response backpressure; the consumer must take every rsp_valid pulse.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, init_idx=0. req_ready=0 and busy=1 when CLEAR_ON_RESET=1; req_ready=1 and busy=0 when CLEAR_ON_RESET=0.
- Latency: request accepted at edge N gives rsp_valid at edge N+1, lasting exactly one cycle. Back-to-back requests give back-to-back responses.
- Store memory update happens at the acceptance edge. A load accepted on the very next cycle to the same address returns the new data; no forwarding path is needed.
- INIT duration is exactly 2^(ADDR_W-2) cycles after reset_n rises; req_ready goes high on the following cycle.
- reset_n asserted mid-operation: outputs go immediately to reset values. Any in-flight response is dropped and the FSM restarts from INIT. Memory contents are defined only once INIT completes.
- Highest address: a word at 2^ADDR_W-4 is legal. Addresses do not wrap; range faults apply.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A half with addr[0]=1 faults.
  - A word with addr[1:0]≠0 faults.
- MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment (half ignores addr[0]; word ignores addr[1:0]).
  - No misalignment fault is ever raised.

## Structure
- Shared package/defs: SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10. 2'b11 is reserved.
- Shared package/defs: FSM state encodings ST_INIT and ST_READY.
- Sub-module load_align: combinational; inputs are the 32-bit word, addr[1:0], size and unsigned; output is the extended 32-bit result. Reused by the future cache fill path.

## Test plan
- Reset with ADDR_W=6 and CLEAR_ON_RESET=1 -> busy for exactly 16 cycles, then req_ready=1. A word load at 0x3C returns 0x00000000.
- Word store 0xDEADBEEF at 0x10, then byte loads at 0x10..0x13 -> 0xFFFFFFDE, 0xFFFFFFAD, 0xFFFFFFBE, 0xFFFFFFEF (signed). Unsigned byte load at 0x11 -> 0x000000AD.
- Half store 0x1234 at 0x22 over a zeroed word, then word load at 0x20 -> 0x00001234. Signed half load of stored 0x8001 -> 0xFFFF8001.
- Word load at 0x40 with ADDR_W=6 -> rsp_fault=1 and rdata=0. A prior store to 0x40 leaves memory unchanged (verify a word load at 0x00 is unchanged).
- Word access at 0x12: with MISALIGN_TRAP_EN -> fault and no write. Without it -> the store lands at 0x10.
- Assert reset_n low in the cycle after a load is accepted -> no rsp_valid. Busy restarts and the INIT count restarts from 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: access-size codes and FSM state encodings.
package data_mem_pkg;

   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_RSV = 2'b11
   } size_e;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage

// File: rtl/data_mem_load_align.sv
// Big-endian load lane select plus sign/zero extension; also used by the cache fill path.
module load_align
   import data_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (off)
         2'd0: byte_sel = word[31:24];
         2'd1: byte_sel = word[23:16];
         2'd2: byte_sel = word[15:8];
         default: byte_sel = word[7:0];
      endcase
      // Halves only look at off[1], which also forces alignment when traps are off.
      half_sel = off[1] ? word[15:0] : word[31:16];
   end

   always_comb begin
      result = '0;
      case (size)
         SIZE_B: result = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SIZE_H: result = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         SIZE_W: result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed big-endian data memory with request/response handshake and post-reset clear.
// Optional build macro MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of aligning them.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter bit CLEAR_ON_RESET = 1'b1
)(
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        busy
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int WORDS = 1 << IDX_W;

   logic [31:0]      mem [WORDS];
   state_e           state, state_nxt;
   logic [IDX_W-1:0] init_idx;
   logic [IDX_W-1:0] widx;
   logic [1:0]       off;
   logic             accept, fault, range_fault, size_fault, mis_fault;
   logic [3:0]       be;
   logic [31:0]      wlane;
   logic [31:0]      rd_word, ld_data;

   assign widx        = req_addr[ADDR_W-1:2];
   assign off         = req_addr[1:0];
   assign range_fault = |(req_addr >> ADDR_W);
   assign size_fault  = (req_size == SIZE_RSV);
`ifdef MISALIGN_TRAP_EN
   assign mis_fault   = ((req_size == SIZE_H) && off[0]) || ((req_size == SIZE_W) && (off != 2'b00));
`else
   assign mis_fault   = 1'b0;
`endif
   assign fault  = range_fault || size_fault || mis_fault;
   assign accept = req_valid && req_ready;

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_INIT: begin
            busy = 1'b1;
            if (init_idx == '1) state_nxt = ST_READY;
         end
         ST_READY: req_ready = 1'b1;
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state    <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
         init_idx <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) init_idx <= init_idx + 1'b1;
      end
   end

   // Lane 3 is bits [31:24], the lowest byte address of the word.
   always_comb begin
      be    = 4'b0000;
      wlane = req_wdata;
      case (req_size)
         SIZE_B: begin
            be    = 4'b1000 >> off;
            wlane = {4{req_wdata[7:0]}};
         end
         SIZE_H: begin
            be    = off[1] ? 4'b0011 : 4'b1100;
            wlane = {2{req_wdata[15:0]}};
         end
         SIZE_W: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         mem[init_idx] <= '0;
      end else if (accept && req_write && !fault) begin
         for (int l = 0; l < 4; l++)
            if (be[l]) mem[widx][8*l +: 8] <= wlane[8*l +: 8];
      end
   end

   assign rd_word = mem[widx];

   load_align u_load_align (
      .word        (rd_word),
      .off         (off),
      .size        (req_size),
      .is_unsigned (req_unsigned),
      .result      (ld_data)
   );

   // Response stage: registered one cycle after acceptance.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= accept;
         rsp_fault <= accept && fault;
         rsp_rdata <= (accept && !req_write && !fault) ? ld_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem (ADDR_W=6, CLEAR_ON_RESET=1); honours MISALIGN_TRAP_EN.
module tb_data_mem;

   localparam int ADDR_W = 6;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        busy;

   data_mem #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
      .CLK          (CLK),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_fault    (rsp_fault),
      .busy         (busy)
   );

   always #5 CLK = ~CLK;

   logic [32:0] exp_q[$];
   string       name_q[$];
   string       dname_q[$];
   logic [31:0] dact_q[$];
   logic [31:0] dexp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [32:0] m_e;
   string       m_n;
   logic [31:0] m_a, m_x;

   // Monitor: sole owner of the counters; drains direct checks and scoreboards responses.
   always @(negedge CLK) begin
      while (dname_q.size() > 0) begin
         m_n = dname_q.pop_front();
         m_a = dact_q.pop_front();
         m_x = dexp_q.pop_front();
         checks++;
         if (m_a !== m_x) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", m_n, m_a, m_x);
         end
      end
      if (rsp_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got fault=%b rdata=%h, expected no response", rsp_fault, rsp_rdata);
         end else begin
            m_e = exp_q.pop_front();
            m_n = name_q.pop_front();
            if ({rsp_fault, rsp_rdata} !== m_e) begin
               errors++;
               $display("FAIL %s: got fault=%b rdata=%h, expected fault=%b rdata=%h",
                        m_n, rsp_fault, rsp_rdata, m_e[32], m_e[31:0]);
            end
         end
      end
   end

   task automatic dcheck(input string n, input logic [31:0] act, input logic [31:0] exp);
      dname_q.push_back(n);
      dact_q.push_back(act);
      dexp_q.push_back(exp);
   endtask

   task automatic issue(input string n, input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic flt, input logic [31:0] exp_rd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_size     = sz;
      req_unsigned = uns;
      req_wdata    = wd;
      name_q.push_back(n);
      exp_q.push_back({flt, exp_rd});
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
   endtask

   // Holds a load request during the clear (must be ignored) and counts busy cycles.
   task automatic reset_and_count(input string n);
      int cnt;
      reset_n = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      dcheck({n, "_rst_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
      dcheck({n, "_rst_rsp_rdata"}, rsp_rdata, 32'h0);
      dcheck({n, "_rst_rsp_fault"}, {31'h0, rsp_fault}, 32'h0);
      dcheck({n, "_rst_busy"}, {31'h0, busy}, 32'h1);
      dcheck({n, "_rst_req_ready"}, {31'h0, req_ready}, 32'h0);
      @(negedge CLK);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_size  = 2'b10;
      reset_n   = 1'b1;
      cnt = 0;
      while (busy && cnt < 100) begin
         @(posedge CLK);
         cnt++;
         #1;
      end
      req_valid = 1'b0;
      dcheck({n, "_init_cycles"}, 32'(cnt), 32'd16);
      dcheck({n, "_ready_after_init"}, {31'h0, req_ready}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_and_count("por");
      issue("ld_w_3c_cleared", 1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);

      issue("st_w_10",        1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
      issue("ld_b_10_s",      1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFFDE);
      issue("ld_b_11_s",      1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFFAD);
      issue("ld_b_12_s",      1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFFBE);
      issue("ld_b_13_s",      1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 1'b0, 32'hFFFFFFEF);
      issue("ld_b_11_u",      1'b0, 32'h11, 2'b00, 1'b1, 32'h0, 1'b0, 32'h000000AD);
      issue("ld_h_10_u",      1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 1'b0, 32'h0000DEAD);

      issue("st_h_22",        1'b1, 32'h22, 2'b01, 1'b0, 32'hFFFF1234, 1'b0, 32'h0);
      issue("ld_w_20",        1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b0, 32'h00001234);
      issue("st_h_24",        1'b1, 32'h24, 2'b01, 1'b0, 32'h00008001, 1'b0, 32'h0);
      issue("ld_h_24_s",      1'b0, 32'h24, 2'b01, 1'b0, 32'h0, 1'b0, 32'hFFFF8001);
      issue("st_b_25",        1'b1, 32'h25, 2'b00, 1'b0, 32'h000000FF, 1'b0, 32'h0);
      issue("ld_w_24",        1'b0, 32'h24, 2'b10, 1'b1, 32'h0, 1'b0, 32'h80FF0000);
      issue("ld_h_24_u",      1'b0, 32'h24, 2'b01, 1'b1, 32'h0, 1'b0, 32'h000080FF);

      issue("st_w_40_range",  1'b1, 32'h40, 2'b10, 1'b0, 32'h55AA55AA, 1'b1, 32'h0);
      issue("ld_w_00_intact", 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);
      issue("ld_w_40_range",  1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0);
      issue("ld_hi_addr",     1'b0, 32'h80000000, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0);
      issue("ld_size_rsv",    1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0);

      issue("st_w_3c_top",    1'b1, 32'h3C, 2'b10, 1'b0, 32'h01020304, 1'b0, 32'h0);
      issue("ld_w_3c_top",    1'b0, 32'h3C, 2'b10, 1'b0, 32'h0, 1'b0, 32'h01020304);
      issue("ld_b_3f_u",      1'b0, 32'h3F, 2'b00, 1'b1, 32'h0, 1'b0, 32'h00000004);

`ifdef MISALIGN_TRAP_EN
      issue("st_w_12_mis",    1'b1, 32'h12, 2'b10, 1'b0, 32'hCAFEF00D, 1'b1, 32'h0);
      issue("ld_w_10_after",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
      issue("ld_h_23_mis",    1'b0, 32'h23, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0);
`else
      issue("st_w_12_mis",    1'b1, 32'h12, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0);
      issue("ld_w_10_after",  1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D);
      issue("ld_h_23_mis",    1'b0, 32'h23, 2'b01, 1'b0, 32'h0, 1'b0, 32'h00001234);
`endif

      // Abort: load accepted, then reset the next cycle; its response must never appear.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h10;
      req_size  = 2'b10;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      reset_n   = 1'b0;
      #1;
      dcheck("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      dcheck("abort_busy", {31'h0, busy}, 32'h1);
      reset_and_count("rerst");
      issue("ld_w_10_recleared", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0);

      repeat (3) @(posedge CLK);
      dcheck("pending_rsp", 32'(exp_q.size()), 32'h0);
      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
